// File: rtl/drsstc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drsstc_pkg: shared types/constants for the interrupter and uart.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package drsstc_pkg;

  // conf_par byte positions
  localparam int c_conf_pre   = 0;
  localparam int c_conf_gap   = 1;
  localparam int c_conf_burst = 2;
  localparam int c_conf_off   = 3;
  localparam int c_conf_on    = 4;
  localparam int c_conf_n     = 5;

  localparam int c_on_max_default       = 200;
  localparam int c_conf_par_max_default = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } intr_state_t;

  // A zero tick count would make a phase vanish; treat it as one tick.
  function automatic logic [7:0] min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen: down-counting prescaler, tick every (load_val+1) cycles.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tick_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] r_cnt;
  logic [7:0] r_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 8'd0;
      r_period <= 8'd0;
    end else if (load) begin
      r_cnt    <= load_val;
      r_period <= load_val;
    end else if (r_cnt == 8'd0) begin
      r_cnt <= r_period;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign tick = (r_cnt == 8'd0);

endmodule
`default_nettype wire

// File: rtl/interrupter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | interrupter: burst-mode gate-drive timing FSM (IDLE/ON/OFF/GAP).     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module interrupter
  import drsstc_pkg::*;
#(
  parameter int CONF_PAR_MAX = c_conf_par_max_default,
  parameter int ON_MAX       = c_on_max_default
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0][7:0]     conf_par,
  input  logic                en,
  output logic                intr,
  output logic                pulse_start,
  output logic                busy
);

  localparam logic [7:0] c_on_max  = 8'(ON_MAX);
  localparam logic [7:0] c_cnt_sat = 8'(CONF_PAR_MAX);

  intr_state_t r_state;
  intr_state_t w_state_nxt;

  logic [7:0] r_sh_on, r_sh_off, r_sh_burst, r_sh_gap, r_sh_pre;
  logic [7:0] r_phase_cnt;
  logic [7:0] r_pulse_cnt;
  logic       r_intr, r_pulse_start, r_busy;

  logic       w_tick;
  logic       w_load;
  logic       w_snap;
  logic       w_cnt_inc;
  logic       w_cnt_clr;
  logic [7:0] w_pre_ld;
  logic [7:0] w_phase_ld;
  logic [7:0] w_conf_on;
  logic [7:0] w_conf_on_eff;
  logic       w_phase_end;
  logic       w_last_pulse;

  assign w_conf_on     = conf_par[c_conf_on];
  assign w_conf_on_eff = (w_conf_on > c_on_max) ? c_on_max : w_conf_on;
  assign w_phase_end   = w_tick && (r_phase_cnt == 8'd1);
  // Pulse counter holds completed OFF phases, so the current pulse is number cnt+1.
  assign w_last_pulse  = (r_sh_burst != 8'd0) && (r_pulse_cnt == r_sh_burst - 8'd1);

  tick_gen u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_pre_ld),
    .tick     (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_snap      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_pre_ld    = r_sh_pre;
    w_phase_ld  = r_phase_cnt;

    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_conf_on != 8'd0) begin
            w_state_nxt = ST_ON;
            w_snap      = 1'b1;
            w_load      = 1'b1;
            w_pre_ld    = conf_par[c_conf_pre];
            w_phase_ld  = w_conf_on_eff;
          end
        end
        ST_ON: begin
          if (w_phase_end) begin
            w_load = 1'b1;
            if (w_last_pulse) begin
              w_state_nxt = ST_GAP;
              w_phase_ld  = r_sh_gap;
            end else begin
              w_state_nxt = ST_OFF;
              w_phase_ld  = r_sh_off;
            end
          end
        end
        ST_OFF: begin
          if (w_phase_end) begin
            w_state_nxt = ST_ON;
            w_load      = 1'b1;
            w_phase_ld  = r_sh_on;
            w_cnt_inc   = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_phase_end) begin
            w_snap    = 1'b1;
            w_cnt_clr = 1'b1;
            if (w_conf_on == 8'd0) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_ON;
              w_load      = 1'b1;
              w_pre_ld    = conf_par[c_conf_pre];
              w_phase_ld  = w_conf_on_eff;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_intr        <= 1'b0;
      r_pulse_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_intr        <= (w_state_nxt == ST_ON);
      r_pulse_start <= (w_state_nxt == ST_ON) && (r_state != ST_ON);
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_on    <= 8'd0;
      r_sh_off   <= 8'd0;
      r_sh_burst <= 8'd0;
      r_sh_gap   <= 8'd0;
      r_sh_pre   <= 8'd0;
    end else if (w_snap) begin
      r_sh_on    <= w_conf_on_eff;
      r_sh_off   <= min1(conf_par[c_conf_off]);
      r_sh_burst <= conf_par[c_conf_burst];
      r_sh_gap   <= min1(conf_par[c_conf_gap]);
      r_sh_pre   <= conf_par[c_conf_pre];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_cnt <= 8'd0;
      r_pulse_cnt <= 8'd0;
    end else begin
      if (w_state_nxt == ST_IDLE) begin
        r_phase_cnt <= 8'd0;
      end else if (w_load) begin
        r_phase_cnt <= w_phase_ld;
      end else if (w_tick && (r_phase_cnt != 8'd0)) begin
        r_phase_cnt <= r_phase_cnt - 8'd1;
      end

      // Saturate rather than wrap so continuous mode never aliases a burst count.
      if ((w_state_nxt == ST_IDLE) || w_cnt_clr) begin
        r_pulse_cnt <= 8'd0;
      end else if (w_cnt_inc && (r_pulse_cnt != c_cnt_sat)) begin
        r_pulse_cnt <= r_pulse_cnt + 8'd1;
      end
    end
  end

  assign intr        = r_intr;
  assign pulse_start = r_pulse_start;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_interrupter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_interrupter: randomized bench against a phase-length model.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_interrupter;

  localparam int ON_MAX = 200;

  typedef struct packed {
    logic [7:0] ton;
    logic [7:0] toff;
    logic [7:0] burst;
    logic [7:0] tgap;
    logic [7:0] pre;
  } cfg_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [4:0][7:0] conf_par;
  logic            intr;
  logic            pulse_start;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0] exp_q[$];  // {intr, pulse_start, busy} per cycle
  logic [2:0] obs_q[$];

  always #5 clk = ~clk;

  interrupter #(
    .CONF_PAR_MAX (255),
    .ON_MAX       (ON_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .conf_par    (conf_par),
    .en          (en),
    .intr        (intr),
    .pulse_start (pulse_start),
    .busy        (busy)
  );

  task automatic apply_cfg(input cfg_t c);
    conf_par[4] = c.ton;
    conf_par[3] = c.toff;
    conf_par[2] = c.burst;
    conf_par[1] = c.tgap;
    conf_par[0] = c.pre;
  endtask

  // Waveform from phase lengths: a burst uses the config present at its start,
  // every later burst uses b. Last entry is the idle sample after en drops.
  task automatic build_expected(input cfg_t a, input cfg_t b, input int ncyc);
    cfg_t c;
    int per, on_len, off_len, gap_len, k;
    c = a;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      if (c.ton == 8'd0) begin
        while (exp_q.size() < ncyc) exp_q.push_back(3'b000);
        break;
      end
      per     = int'(c.pre) + 1;
      on_len  = ((int'(c.ton) > ON_MAX) ? ON_MAX : int'(c.ton)) * per;
      off_len = ((c.toff == 8'd0) ? 1 : int'(c.toff)) * per;
      gap_len = ((c.tgap == 8'd0) ? 1 : int'(c.tgap)) * per;
      k = 0;
      while (exp_q.size() < ncyc) begin
        for (int i = 0; i < on_len; i++) exp_q.push_back((i == 0) ? 3'b111 : 3'b101);
        k++;
        if ((c.burst != 8'd0) && (k == int'(c.burst))) begin
          for (int i = 0; i < gap_len; i++) exp_q.push_back(3'b001);
          break;
        end
        for (int i = 0; i < off_len; i++) exp_q.push_back(3'b001);
      end
      c = b;
    end
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    exp_q.push_back(3'b000);
  endtask

  // Enables with config a, switches conf_par to b after sample change_at,
  // records ncyc samples plus one after en is dropped.
  task automatic capture(input cfg_t a, input cfg_t b, input int change_at, input int ncyc);
    obs_q.delete();
    @(negedge clk);
    en = 1'b0;
    apply_cfg(a);
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      obs_q.push_back({intr, pulse_start, busy});
      if (i == change_at) apply_cfg(b);
    end
    en = 1'b0;
    @(negedge clk);
    obs_q.push_back({intr, pulse_start, busy});
  endtask

  task automatic test_reset();
    cfg_t c;
    rst_n = 1'b0;
    en = 1'b0;
    conf_par = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({intr, pulse_start, busy} !== 3'b000)
      $display("FAIL reset_state: got %b want 000", {intr, pulse_start, busy});
    else n_pass++;
    rst_n = 1'b1;
    c = '{ton: 8'd5, toff: 8'd3, burst: 8'd0, tgap: 8'd1, pre: 8'd0};
    apply_cfg(c);
    repeat (2) @(negedge clk);
    n_total++;
    if ({intr, pulse_start, busy} !== 3'b000)
      $display("FAIL reset_wait_en: got %b want 000", {intr, pulse_start, busy});
    else n_pass++;

    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({intr, pulse_start, busy} !== 3'b000)
      $display("FAIL reset_async_mid_on: got %b want 000", {intr, pulse_start, busy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    build_expected(c, c, 12);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_total++;
      if ({intr, pulse_start, busy} !== exp_q[i])
        $display("FAIL reset_restart cycle %0d: got %b want %b", i, {intr, pulse_start, busy}, exp_q[i]);
      else n_pass++;
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    cfg_t c;
    logic [11:0] pat;
    logic [2:0]  want;
    pat = 12'b111001110000;
    c = '{ton: 8'd3, toff: 8'd2, burst: 8'd2, tgap: 8'd4, pre: 8'd0};
    capture(c, c, -1, 24);
    for (int i = 0; i < 24; i++) begin
      want = {pat[11 - (i % 12)], ((i % 12) == 0) || ((i % 12) == 5), 1'b1};
      n_total++;
      if (obs_q[i] !== want)
        $display("FAIL burst cycle %0d: got %b want %b", i, obs_q[i], want);
      else n_pass++;
    end
    n_total++;
    if (obs_q[24] !== 3'b000) $display("FAIL burst_stop: got %b want 000", obs_q[24]);
    else n_pass++;
  endtask

  task automatic test_prescaled();
    cfg_t c;
    c = '{ton: 8'd2, toff: 8'd1, burst: 8'd0, tgap: 8'd7, pre: 8'd1};
    build_expected(c, c, 30);
    capture(c, c, -1, 30);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL prescaled cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    cfg_t c;
    int highs;
    c = '{ton: 8'd250, toff: 8'd3, burst: 8'd0, tgap: 8'd1, pre: 8'd0};
    build_expected(c, c, 210);
    capture(c, c, -1, 210);
    highs = 0;
    for (int i = 0; i < 210; i++) begin
      if (obs_q[i][2] && (highs == i)) highs++;
    end
    n_total++;
    if (highs !== 200) $display("FAIL clamp_on_len: got %0d cycles want 200", highs);
    else n_pass++;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL clamp cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    cfg_t a, b;
    a = '{ton: 8'd3, toff: 8'd2, burst: 8'd2, tgap: 8'd4, pre: 8'd0};
    b = a;
    b.ton = 8'd6;
    build_expected(a, b, 40);
    capture(a, b, 2, 40);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL snapshot cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_abort_and_zero();
    cfg_t c;
    logic seen;
    c = '{ton: 8'd5, toff: 8'd2, burst: 8'd0, tgap: 8'd1, pre: 8'd0};
    @(negedge clk);
    apply_cfg(c);
    en = 1'b1;
    @(negedge clk);
    n_total++;
    if ({intr, pulse_start, busy} !== 3'b111)
      $display("FAIL abort_first_on: got %b want 111", {intr, pulse_start, busy});
    else n_pass++;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_total++;
    if ({intr, pulse_start, busy} !== 3'b000)
      $display("FAIL abort_next_cycle: got %b want 000", {intr, pulse_start, busy});
    else n_pass++;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | intr | busy;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL abort_stays_idle: got activity 1 want 0");
    else n_pass++;

    c.ton = 8'd0;
    apply_cfg(c);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_total++;
      if ({intr, pulse_start, busy} !== 3'b000)
        $display("FAIL zero_on cycle %0d: got %b want 000", i, {intr, pulse_start, busy});
      else n_pass++;
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    cfg_t a, b;
    for (int t = 0; t < 14; t++) begin
      a.ton   = 8'($urandom_range(0, 8));
      a.toff  = 8'($urandom_range(0, 4));
      a.burst = 8'($urandom_range(0, 3));
      a.tgap  = 8'($urandom_range(0, 4));
      a.pre   = 8'($urandom_range(0, 2));
      b.ton   = 8'($urandom_range(0, 8));
      b.toff  = 8'($urandom_range(0, 4));
      b.burst = 8'($urandom_range(0, 3));
      b.tgap  = 8'($urandom_range(0, 4));
      b.pre   = 8'($urandom_range(0, 2));
      if (a.ton == 8'd0) b = a;
      build_expected(a, b, 100);
      capture(a, b, 0, 100);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL random%0d cycle %0d: got %b want %b", t, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    conf_par = '0;
    test_reset();
    test_burst();
    test_prescaled();
    test_clamp();
    test_snapshot();
    test_abort_and_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupter.md
INTERRUPTER -- requirements
Module: interrupter

Interface
REQ-001 SHALL have parameter CONF_PAR_MAX, default 255, the maximum value of one configuration byte (8 bits).
REQ-002 SHALL have parameter ON_MAX, default 200, the ceiling on ON time in ticks (coil protection).
REQ-003 SHALL have port clk  input  1  the single system clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port conf_par  input  5 x 8  configuration bytes from the UART receiver.
- Index 4: on_t (ticks).
- Index 3: off_t (ticks).
- Index 2: burst_n (pulses per burst; 0 = continuous).
- Index 1: gap_t (ticks).
- Index 0: pre (tick = pre+1 clk cycles).
REQ-006 SHALL have port en  input  1  run enable, synchronous to clk.
REQ-007 SHALL have port intr  output  1  registered gate-drive interrupter output.
REQ-008 SHALL have port pulse_start  output  1  one-cycle strobe in the first cycle of each ON phase.
REQ-009 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-010 SHALL implement the states IDLE, ON, OFF and GAP; intr SHALL be 1 only in ON.
REQ-011 SHALL snapshot conf_par into shadow registers only in two situations:
- on IDLE->ON;
- on GAP->ON.
Mid-burst UART writes SHALL NOT affect timing.
REQ-012 SHALL apply these shadow load rules:
- on_eff = min(on_t, ON_MAX);
- off_t = 0 is treated as 1;
- gap_t = 0 is treated as 1.
REQ-013 IDLE->ON SHALL occur at the clock edge where en=1 and the conf_par on_t is nonzero; intr=1 and pulse_start=1 SHALL hold in the following cycle (1-cycle latency).
REQ-014 Each phase SHALL last exactly (phase ticks) x (pre+1) clk cycles; the prescaler and phase counter SHALL reload on every phase entry.
REQ-015 At ON end:
- if burst_n = 0, or pulses done < burst_n: go to OFF;
- otherwise: go to GAP, with OFF skipped.
REQ-016 OFF end SHALL go to ON and increment the pulse counter.
REQ-017 GAP end SHALL clear the pulse counter, reload the shadow registers and go to ON.
- If the reloaded on_t = 0, it SHALL go to IDLE instead.
REQ-018 en=0 in any state SHALL force the following in the next cycle:
- state to IDLE;
- intr to 0;
- pulse_start to 0.
No pulse SHALL be completed after en falls.
REQ-019 SHALL use counters 8 bits wide; the prescaler SHALL be 8 bits; the pulse counter SHALL be 8 bits and never wrap (it is compared for equality against burst_n).
REQ-020 SHALL contain no combinational path from any input to intr.

Reset
REQ-021 rst_n=0 SHALL asynchronously force:
- state = IDLE;
- intr = 0, pulse_start = 0, busy = 0;
- all counters and shadow registers to 0.
REQ-022 After rst_n deasserts, the block SHALL wait for en=1 with on_t nonzero before leaving IDLE.
REQ-023 Reset asserted mid-ON SHALL drop intr in the same cycle (asynchronously).

Structure
REQ-024 The state enum, the conf_par index localparams (CONF_PAR_0..4 mapping) and ON_MAX default SHALL reside in shared package drsstc_pkg, also used by uart.
REQ-025 SHALL instantiate one sub-module tick_gen (a down-counting prescaler with load and tick output); the rest of the logic SHALL be one FSM.

Verification
REQ-026 Burst case: pre=0, on=3, off=2, burst=2, gap=4, en=1 -> intr sequence 1,1,1,0,0,1,1,1,0,0,0,0, repeating every 12 cycles; pulse_start on cycles 1 and 6.
REQ-027 Prescaled continuous case: pre=1, on=2, off=1, burst=0 -> intr high 4 cycles, low 2 cycles, repeating; busy stays 1.
REQ-028 Clamp case: on=250 with ON_MAX=200, pre=0 -> ON lasts exactly 200 cycles.
REQ-029 Snapshot case: conf_par on_t changed from 3 to 6 mid-burst -> the current burst keeps 3-cycle pulses; the first pulse after GAP is 6 cycles.
REQ-030 Abort and zero case:
- en dropped on the 2nd cycle of ON -> intr=0 and state IDLE in the next cycle;
- on_t=0 with en=1 -> stays IDLE, intr never 1.
REQ-031 Reset case: rst_n pulsed low mid-ON -> intr=0 immediately; after release with en=1, the first pulse starts 1 cycle later with full on_t.
